// File: rtl/wb_uart_pkg.sv
// Register map, status bit positions and FSM state type shared by the
// wb_uart top level and its receiver.
package wb_uart_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_RXDATA = 2'd1;
    localparam logic [1:0] UART_STATUS = 2'd2;
    localparam logic [1:0] UART_DIV    = 2'd3;

    localparam int ST_TX_READY = 0;
    localparam int ST_TX_BUSY  = 1;
    localparam int ST_RX_VALID = 2;
    localparam int ST_RX_OVR   = 3;
    localparam int ST_RX_FERR  = 4;
    localparam int ST_TX_OVR   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/wb_uart_if.sv
// Wishbone pipelined data-bus bundle between the J1 CPU and its peripherals.
interface if_wb;
    logic [15:0] adr;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        stall;
    logic        ack;

    modport master (output adr, dat_i, cyc, stb, we, input dat_o, stall, ack);
    modport slave  (input adr, dat_i, cyc, stb, we, output dat_o, stall, ack);
endinterface

// File: rtl/wb_uart_rx.sv
// UART receiver: 2-flop synchroniser, bit-centre down-counter and RX FSM.
// Emits a one-cycle strobe with the byte and the stop-bit error flag.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | half-bit wait, then re-check the start bit (high = false start)
// DATA  | sample 8 data bits at bit centres, LSB first
// STOP  | sample the stop bit at its centre and hand the byte out
module uart_rx
    import wb_uart_pkg::*;
(
    input  logic        sys_clk_i,
    input  logic        sys_rst_ni,
    input  logic        rxd,
    input  logic [15:0] divisor,
    output logic        byte_stb,
    output logic [7:0]  byte_data,
    output logic        frame_err
);

    logic        rxd_s1, rxd_s2, rxd_prev;
    uart_state_t state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        tick;

    assign tick      = (cnt == 16'd0);
    assign byte_data = shreg;

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = tick ? divisor : cnt - 16'd1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        byte_stb    = 1'b0;
        frame_err   = 1'b0;
        case (state)
            IDLE: begin
                // preload half a bit so START lands on the start-bit centre
                cnt_nxt = {1'b0, divisor[15:1]};
                if (rxd_prev && !rxd_s2) state_nxt = START;
            end
            START: begin
                if (tick) begin
                    if (rxd_s2) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = DATA;
                        bit_idx_nxt = 3'd0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_nxt   = {rxd_s2, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    byte_stb  = 1'b1;
                    frame_err = !rxd_s2;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/wb_uart.sv
// Wishbone slave UART: four-word register file, TX holding register and
// shifter, RX holding register and status flags. Reads never have side effects.
//
// state | meaning
// IDLE  | line high, waiting for the holding register to fill
// START | driving the start bit
// DATA  | shifting 8 data bits out, LSB first
// STOP  | driving the stop bit; reloads straight into START if data waits
module wb_uart
    import wb_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADR  = 16'h0000,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic sys_clk_i,
    input  logic sys_rst_ni,
    if_wb.slave  wbs,
    input  logic uart_rxd_i,
    output logic uart_txd_o,
    output logic irq_o
);

    logic        sel;
    logic [1:0]  offset;
    logic        wr_tx, wr_status, wr_div, pop;
    logic [15:0] divisor;
    logic [15:0] rd_data;

    logic [7:0]  tx_hold, tx_shift;
    logic        tx_full, tx_ovr, tx_ready, tx_busy;
    uart_state_t tx_state, tx_state_nxt;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic        tx_tick, tx_load;

    logic        rx_valid, rx_ovr, rx_ferr;
    logic [7:0]  rx_byte;
    logic        byte_stb, frame_err, store;
    logic [7:0]  byte_data;

    assign sel       = wbs.cyc && wbs.stb && (wbs.adr[15:2] == BASE_ADR[15:2]);
    assign offset    = wbs.adr[1:0];
    assign wr_tx     = sel && wbs.we && (offset == UART_TXDATA);
    assign wr_status = sel && wbs.we && (offset == UART_STATUS);
    assign wr_div    = sel && wbs.we && (offset == UART_DIV);
    assign pop       = wr_status && wbs.dat_i[ST_RX_VALID];

    assign wbs.stall = 1'b0;
    assign tx_ready  = !tx_full;
    assign tx_busy   = (tx_state != IDLE);
    assign irq_o     = rx_valid;
    // a pop in the completion cycle frees the slot for the incoming byte
    assign store     = byte_stb && (!rx_valid || pop);

    always_comb begin
        rd_data = 16'd0;
        case (offset)
            UART_RXDATA: rd_data = {rx_valid, 7'd0, rx_byte};
            UART_STATUS: begin
                rd_data[ST_TX_READY] = tx_ready;
                rd_data[ST_TX_BUSY]  = tx_busy;
                rd_data[ST_RX_VALID] = rx_valid;
                rd_data[ST_RX_OVR]   = rx_ovr;
                rd_data[ST_RX_FERR]  = rx_ferr;
                rd_data[ST_TX_OVR]   = tx_ovr;
            end
            UART_DIV:    rd_data = divisor;
            default:     rd_data = 16'd0;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            wbs.ack   <= 1'b0;
            wbs.dat_o <= 16'd0;
        end else begin
            wbs.ack   <= sel;
            wbs.dat_o <= (sel && !wbs.we) ? rd_data : 16'd0;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            divisor  <= DIV_RESET;
            tx_hold  <= 8'd0;
            tx_full  <= 1'b0;
            tx_ovr   <= 1'b0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_byte  <= 8'd0;
        end else begin
            if (wr_div) divisor <= wbs.dat_i;

            // tx_load only happens with tx_full set, so it never races an accept
            if (wr_tx && !tx_full) begin
                tx_hold <= wbs.dat_i[7:0];
                tx_full <= 1'b1;
            end else if (tx_load) begin
                tx_full <= 1'b0;
            end

            if (wr_tx && tx_full)                        tx_ovr <= 1'b1;
            else if (wr_status && wbs.dat_i[ST_TX_OVR])  tx_ovr <= 1'b0;

            if (store) begin
                rx_byte  <= byte_data;
                rx_valid <= 1'b1;
            end else if (pop) begin
                rx_valid <= 1'b0;
            end

            if (byte_stb && rx_valid && !pop)            rx_ovr <= 1'b1;
            else if (wr_status && wbs.dat_i[ST_RX_OVR])  rx_ovr <= 1'b0;

            if (store && frame_err)                      rx_ferr <= 1'b1;
            else if (wr_status && wbs.dat_i[ST_RX_FERR]) rx_ferr <= 1'b0;
        end
    end

    assign tx_tick = (tx_cnt == 16'd0);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_load      = 1'b0;
        case (tx_state)
            IDLE: begin
                if (tx_full) begin
                    tx_load      = 1'b1;
                    tx_state_nxt = START;
                end
            end
            START: if (tx_tick) tx_state_nxt = DATA;
            DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_nxt = STOP;
            STOP: begin
                if (tx_tick) begin
                    if (tx_full) begin
                        tx_load      = 1'b1;
                        tx_state_nxt = START;
                    end else begin
                        tx_state_nxt = IDLE;
                    end
                end
            end
            default: tx_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            tx_state <= IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_load) begin
                tx_shift <= tx_hold;
                tx_cnt   <= divisor;
                tx_bit   <= 3'd0;
            end else if (tx_state != IDLE) begin
                // divisor is re-read at every bit boundary
                if (tx_tick) begin
                    tx_cnt <= divisor;
                    if (tx_state == DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    always_comb begin
        case (tx_state)
            START:   uart_txd_o = 1'b0;
            DATA:    uart_txd_o = tx_shift[0];
            default: uart_txd_o = 1'b1;
        endcase
    end

    uart_rx u_rx (
        .sys_clk_i  (sys_clk_i),
        .sys_rst_ni (sys_rst_ni),
        .rxd        (uart_rxd_i),
        .divisor    (divisor),
        .byte_stb   (byte_stb),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

endmodule

// File: tb/tb_wb_uart.sv
// Directed/randomised bench for wb_uart with a flag-level reference model.
module tb_wb_uart;
    import wb_uart_pkg::*;

    logic sys_clk_i  = 1'b0;
    logic sys_rst_ni = 1'b0;
    logic uart_rxd_i = 1'b1;
    logic uart_txd_o;
    logic irq_o;

    if_wb wbs_if ();

    wb_uart #(.BASE_ADR(16'h0000), .DIV_RESET(16'd433)) dut (
        .sys_clk_i  (sys_clk_i),
        .sys_rst_ni (sys_rst_ni),
        .wbs        (wbs_if.slave),
        .uart_rxd_i (uart_rxd_i),
        .uart_txd_o (uart_txd_o),
        .irq_o      (irq_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_edge = 0;
    logic txlog [0:8191];

    always @(posedge sys_clk_i) cyc <= cyc + 1;
    always @(negedge sys_clk_i) if (cyc < 8192) txlog[cyc] = uart_txd_o;

    // reference model of the software-visible flags
    bit         m_rx_valid, m_rx_ovr, m_rx_ferr, m_tx_ovr;
    logic [7:0] m_rx_byte;

    function automatic logic [15:0] exp_status(input bit ready, input bit busy);
        return {10'd0, m_tx_ovr, m_rx_ferr, m_rx_ovr, m_rx_valid, busy, ready};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [15:0] d);
        wbs_if.adr   = {14'd0, off};
        wbs_if.dat_i = d;
        wbs_if.we    = 1'b1;
        wbs_if.cyc   = 1'b1;
        wbs_if.stb   = 1'b1;
        @(posedge sys_clk_i);
        #1;
        last_edge  = cyc;
        wbs_if.cyc = 1'b0;
        wbs_if.stb = 1'b0;
        wbs_if.we  = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] off, output logic [15:0] d, output logic ack);
        wbs_if.adr = {14'd0, off};
        wbs_if.we  = 1'b0;
        wbs_if.cyc = 1'b1;
        wbs_if.stb = 1'b1;
        @(posedge sys_clk_i);
        #1;
        d   = wbs_if.dat_o;
        ack = wbs_if.ack;
        wbs_if.cyc = 1'b0;
        wbs_if.stb = 1'b0;
    endtask

    task automatic model_w1c(input logic [15:0] m);
        if (m[2]) m_rx_valid = 1'b0;
        if (m[3]) m_rx_ovr   = 1'b0;
        if (m[4]) m_rx_ferr  = 1'b0;
        if (m[5]) m_tx_ovr   = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        uart_rxd_i = 1'b0;
        wait_cyc(16);
        for (int i = 0; i < 8; i++) begin
            uart_rxd_i = b[i];
            wait_cyc(16);
        end
        uart_rxd_i = stop;
        wait_cyc(16);
        uart_rxd_i = 1'b1;
        wait_cyc(8);
        if (m_rx_valid) begin
            m_rx_ovr = 1'b1;
        end else begin
            m_rx_valid = 1'b1;
            m_rx_byte  = b;
            if (!stop) m_rx_ferr = 1'b1;
        end
    endtask

    // frame starting at log index s: bit k spans s+16k .. s+16k+15
    task automatic chk_frame(input int s, input logic [7:0] b, input string tag);
        logic e;
        chk({tag, "_start_edge"}, 16'(txlog[s]), 16'd0);
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      e = 1'b0;
            else if (k == 9) e = 1'b1;
            else             e = 1'((b >> (k - 1)) & 8'd1);
            chk($sformatf("%s_bit%0d", tag, k), 16'(txlog[s + 16 * k + 8]), 16'(e));
        end
        chk({tag, "_stop_end"}, 16'(txlog[s + 159]), 16'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic        rd_ack;
        logic [7:0]  b0, b1, b2, c;
        int          t0;

        wbs_if.adr = 16'd0; wbs_if.dat_i = 16'd0;
        wbs_if.cyc = 1'b0;  wbs_if.stb = 1'b0; wbs_if.we = 1'b0;
        m_rx_valid = 0; m_rx_ovr = 0; m_rx_ferr = 0; m_tx_ovr = 0; m_rx_byte = 8'd0;

        wait_cyc(3);
        sys_rst_ni = 1'b1;
        wait_cyc(2);
        chk("rst_ack",   16'(wbs_if.ack), 16'd0);
        chk("rst_dat_o", wbs_if.dat_o,    16'd0);
        chk("rst_stall", 16'(wbs_if.stall), 16'd0);
        chk("rst_txd",   16'(uart_txd_o), 16'd1);
        chk("rst_irq",   16'(irq_o),      16'd0);

        bus_read(UART_STATUS, d, rd_ack);
        chk("status_rst", d, exp_status(1, 0));
        chk("ack_read", 16'(rd_ack), 16'd1);
        wait_cyc(1);
        chk("ack_single", 16'(wbs_if.ack), 16'd0);
        chk("dat_o_idle", wbs_if.dat_o, 16'd0);
        bus_read(UART_DIV, d, rd_ack);
        chk("div_rst", d, 16'd433);
        bus_write(UART_DIV, 16'd15);
        bus_read(UART_DIV, d, rd_ack);
        chk("div_wr", d, 16'd15);

        // TX: back-to-back frames, then an overrun on the holding register
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        bus_write(UART_TXDATA, {8'd0, b0});
        t0 = last_edge;
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_after_wr", d, exp_status(0, 0));
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_loaded", d, exp_status(1, 1));
        wait_cyc(20);
        bus_write(UART_TXDATA, {8'd0, b1});
        bus_write(UART_TXDATA, {8'd0, b2});
        m_tx_ovr = 1'b1;
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_tx_ovr", d, exp_status(0, 1));
        bus_write(UART_STATUS, 16'h0020);
        model_w1c(16'h0020);
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_tx_ovr_clr", d, exp_status(0, 1));
        wait_cyc(340);
        chk("tx_idle_before", 16'(txlog[t0]), 16'd1);
        chk_frame(t0 + 1, b0, "tx_f0");
        chk_frame(t0 + 161, b1, "tx_f1");
        chk("tx_idle_after", 16'(txlog[t0 + 321]), 16'd1);
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_tx_done", d, exp_status(1, 0));

        // RX: single byte, non-destructive reads, pop
        c = 8'($urandom);
        send_rx(c, 1'b1);
        chk("irq_set", 16'(irq_o), 16'(m_rx_valid));
        bus_read(UART_RXDATA, d, rd_ack);
        chk("rxdata", d, {m_rx_valid, 7'd0, m_rx_byte});
        bus_read(UART_RXDATA, d, rd_ack);
        chk("rxdata_reread", d, {m_rx_valid, 7'd0, m_rx_byte});
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_rx", d, exp_status(1, 0));
        bus_write(UART_STATUS, 16'h0004);
        model_w1c(16'h0004);
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_pop", d, exp_status(1, 0));
        chk("irq_clr", 16'(irq_o), 16'd0);

        // RX overrun
        send_rx(8'($urandom), 1'b1);
        send_rx(8'($urandom), 1'b1);
        bus_read(UART_RXDATA, d, rd_ack);
        chk("rxdata_ovr", d, {m_rx_valid, 7'd0, m_rx_byte});
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_rx_ovr", d, exp_status(1, 0));
        bus_write(UART_STATUS, 16'h000C);
        model_w1c(16'h000C);
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_ovr_clr", d, exp_status(1, 0));

        // RX framing error: byte still delivered
        send_rx(8'($urandom), 1'b0);
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_ferr", d, exp_status(1, 0));
        bus_read(UART_RXDATA, d, rd_ack);
        chk("rxdata_ferr", d, {m_rx_valid, 7'd0, m_rx_byte});
        bus_write(UART_STATUS, 16'h0014);
        model_w1c(16'h0014);
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_ferr_clr", d, exp_status(1, 0));

        // short low glitch is a false start
        uart_rxd_i = 1'b0;
        wait_cyc(4);
        uart_rxd_i = 1'b1;
        wait_cyc(200);
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_glitch", d, exp_status(1, 0));
        chk("irq_glitch", 16'(irq_o), 16'd0);

        // reset in the middle of a TX frame with a byte pending
        send_rx(8'($urandom), 1'b1);
        chk("irq_pre_rst", 16'(irq_o), 16'd1);
        bus_write(UART_TXDATA, 16'($urandom_range(0, 255)));
        wait_cyc(30);
        sys_rst_ni = 1'b0;
        #1;
        chk("txd_in_rst", 16'(uart_txd_o), 16'd1);
        chk("irq_in_rst", 16'(irq_o), 16'd0);
        m_rx_valid = 0; m_rx_ovr = 0; m_rx_ferr = 0; m_tx_ovr = 0;
        wait_cyc(2);
        sys_rst_ni = 1'b1;
        wait_cyc(2);
        bus_read(UART_STATUS, d, rd_ack);
        chk("status_post_rst", d, exp_status(1, 0));
        bus_read(UART_DIV, d, rd_ack);
        chk("div_post_rst", d, 16'd433);
        chk("txd_post_rst", 16'(uart_txd_o), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
